// File: rtl/snes_osd_menu_pkg.sv
// Shared definitions for the OSD menu: state encodings, pad bit indices,
// item rows, setting limits/reset values and small step helpers.
package snes_osd_menu_pkg;

    typedef enum logic [2:0] {
        ST_HIDDEN,
        ST_ARM,
        ST_WAIT_OPEN,
        ST_MENU,
        ST_WAIT_CLOSE
    } menu_state_e;

    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    localparam logic [3:0] PAD_ID_STD = 4'hF;

    localparam logic [1:0] ROW_BRIGHT   = 2'd0;
    localparam logic [1:0] ROW_REGION   = 2'd1;
    localparam logic [1:0] ROW_SCANLINE = 2'd2;
    localparam logic [1:0] ROW_RESET    = 2'd3;

    localparam logic [3:0] BRIGHT_LIMIT   = 4'd15;
    localparam logic [3:0] BRIGHT_RST     = 4'd15;
    localparam logic [1:0] REGION_LIMIT   = 2'd2;
    localparam logic [1:0] REGION_RST     = 2'd0;
    localparam logic [1:0] SCANLINE_LIMIT = 2'd3;
    localparam logic [1:0] SCANLINE_RST   = 2'd0;

    function automatic logic open_combo(input logic [11:0] p);
        return p[BTN_L] & p[BTN_R] & p[BTN_SELECT] & p[BTN_START];
    endfunction

    function automatic logic [3:0] step_sat4(input logic [3:0] v, input logic [3:0] lim,
                                             input logic inc, input logic dec);
        logic [3:0] r;
        r = v;
        if (inc && (v < lim)) r = v + 4'd1;
        else if (dec && (v != 4'd0)) r = v - 4'd1;
        return r;
    endfunction

    function automatic logic [1:0] step_sat2(input logic [1:0] v, input logic [1:0] lim,
                                             input logic inc, input logic dec);
        logic [1:0] r;
        r = v;
        if (inc && (v < lim)) r = v + 2'd1;
        else if (dec && (v != 2'd0)) r = v - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/snes_pad_edge.sv
// Pad word decoder: pressed/new-press vectors and Left/Right repeat strobes.
// Repeat logic exists only when SNES_OSD_MENU_AUTOREPEAT_EN is defined.
module snes_pad_edge
    import snes_osd_menu_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] pad_i,
    input  logic        pad_valid_i,
    input  logic        rep_clr_i,
    output logic [11:0] pressed_o,
    output logic [11:0] new_o,
    output logic        rep_left_o,
    output logic        rep_right_o
);

    logic [11:0] prev_q, prev_d;

    // Non-standard or absent pads read as nothing pressed.
    assign pressed_o = (pad_i[15:12] == PAD_ID_STD) ? ~pad_i[11:0] : 12'h000;
    assign new_o     = pressed_o & ~prev_q;

    always_comb begin
        prev_d = prev_q;
        if (pad_valid_i) prev_d = pressed_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= 12'h000;
        else       prev_q <= prev_d;
    end

`ifdef SNES_OSD_MENU_AUTOREPEAT_EN
    localparam logic [7:0] DELAY_W  = 8'(REPEAT_DELAY);
    localparam logic [7:0] RELOAD_W = 8'(REPEAT_DELAY - REPEAT_RATE);

    logic [7:0] rep_q, rep_d;
    logic       rep_fire;

    // Counts accepted words since the last restart; a restart is a fresh
    // L/R press, both/neither held, or a cursor move.
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (pad_valid_i) begin
            if (rep_clr_i || new_o[BTN_LEFT] || new_o[BTN_RIGHT] ||
                !(pressed_o[BTN_LEFT] ^ pressed_o[BTN_RIGHT])) begin
                rep_d = 8'd0;
            end else if (rep_q + 8'd1 == DELAY_W) begin
                rep_fire = 1'b1;
                rep_d    = RELOAD_W;
            end else begin
                rep_d = rep_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rep_q <= 8'd0;
        else       rep_q <= rep_d;
    end

    assign rep_left_o  = rep_fire & pressed_o[BTN_LEFT];
    assign rep_right_o = rep_fire & pressed_o[BTN_RIGHT];
`else
    logic unused_rep;
    assign unused_rep  = rep_clr_i ^ (REPEAT_DELAY != REPEAT_RATE);
    assign rep_left_o  = 1'b0;
    assign rep_right_o = 1'b0;
`endif

endmodule

// File: rtl/snes_osd_menu.sv
// OSD menu controller: open/navigate/edit/close FSM driven by the pad word.
// Optional Left/Right auto-repeat: define SNES_OSD_MENU_AUTOREPEAT_EN.
module snes_osd_menu
    import snes_osd_menu_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES  = 8,
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 4
) (
    input  logic        CLK_i,
    input  logic        RST_i,
    input  logic [15:0] PAD_i,
    input  logic        PAD_VALID_i,
    output logic        OSD_EN_o,
    output logic [1:0]  CURSOR_o,
    output logic [3:0]  BRIGHT_MAX_o,
    output logic [1:0]  REGION_o,
    output logic [1:0]  SCANLINE_o,
    output logic        RST_REQ_o
);

    localparam logic [7:0] HOLD_W = 8'(HOLD_FRAMES);

    menu_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        osd_en_q, osd_en_d;
    logic [1:0]  cursor_q, cursor_d;
    logic [3:0]  bright_q, bright_d;
    logic [1:0]  region_q, region_d;
    logic [1:0]  scanline_q, scanline_d;
    logic        rst_req_q, rst_req_d;

    logic [11:0] pressed, new_press;
    logic        rep_left, rep_right, rep_clr;
    logic        move_up, move_dn, step_inc, step_dec;
    logic        unused_bits;

    snes_pad_edge #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_pad_edge (
        .clk_i      (CLK_i),
        .rst_i      (RST_i),
        .pad_i      (PAD_i),
        .pad_valid_i(PAD_VALID_i),
        .rep_clr_i  (rep_clr),
        .pressed_o  (pressed),
        .new_o      (new_press),
        .rep_left_o (rep_left),
        .rep_right_o(rep_right)
    );

    assign unused_bits = ^new_press;
    assign move_up  = new_press[BTN_UP] & ~new_press[BTN_DOWN];
    assign move_dn  = new_press[BTN_DOWN] & ~new_press[BTN_UP];
    assign step_inc = (new_press[BTN_RIGHT] | rep_right) & ~(new_press[BTN_LEFT] | rep_left);
    assign step_dec = (new_press[BTN_LEFT] | rep_left) & ~(new_press[BTN_RIGHT] | rep_right);
    // A cursor move restarts the repeat timer so a held direction does not
    // immediately step the newly selected item.
    assign rep_clr  = PAD_VALID_i && (state_q == ST_MENU) && !new_press[BTN_B] &&
                      (move_up || move_dn);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        osd_en_d   = osd_en_q;
        cursor_d   = cursor_q;
        bright_d   = bright_q;
        region_d   = region_q;
        scanline_d = scanline_q;
        rst_req_d  = 1'b0;
        if (PAD_VALID_i) begin
            unique case (state_q)
                ST_HIDDEN: begin
                    if (open_combo(pressed)) begin
                        hold_d  = 8'd1;
                        state_d = (HOLD_W <= 8'd1) ? ST_WAIT_OPEN : ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (open_combo(pressed)) begin
                        hold_d = hold_q + 8'd1;
                        if (hold_q + 8'd1 >= HOLD_W) state_d = ST_WAIT_OPEN;
                    end else begin
                        hold_d  = 8'd0;
                        state_d = ST_HIDDEN;
                    end
                end
                ST_WAIT_OPEN: begin
                    if (pressed == 12'h000) begin
                        state_d  = ST_MENU;
                        hold_d   = 8'd0;
                        osd_en_d = 1'b1;
                        cursor_d = 2'd0;
                    end
                end
                ST_MENU: begin
                    if (new_press[BTN_B]) begin
                        state_d = ST_WAIT_CLOSE;
                    end else begin
                        if (move_up)      cursor_d = cursor_q - 2'd1;
                        else if (move_dn) cursor_d = cursor_q + 2'd1;
                        case (cursor_q)
                            ROW_BRIGHT:
                                bright_d = step_sat4(bright_q, BRIGHT_LIMIT, step_inc, step_dec);
                            ROW_REGION:
                                region_d = step_sat2(region_q, REGION_LIMIT, step_inc, step_dec);
                            ROW_SCANLINE:
                                scanline_d = step_sat2(scanline_q, SCANLINE_LIMIT, step_inc, step_dec);
                            ROW_RESET: begin
                                if (new_press[BTN_A]) begin
                                    rst_req_d = 1'b1;
                                    state_d   = ST_WAIT_CLOSE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WAIT_CLOSE: begin
                    if (pressed == 12'h000) begin
                        state_d  = ST_HIDDEN;
                        osd_en_d = 1'b0;
                    end
                end
                default: state_d = ST_HIDDEN;
            endcase
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q    <= ST_HIDDEN;
            hold_q     <= 8'd0;
            osd_en_q   <= 1'b0;
            cursor_q   <= 2'd0;
            bright_q   <= BRIGHT_RST;
            region_q   <= REGION_RST;
            scanline_q <= SCANLINE_RST;
            rst_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            osd_en_q   <= osd_en_d;
            cursor_q   <= cursor_d;
            bright_q   <= bright_d;
            region_q   <= region_d;
            scanline_q <= scanline_d;
            rst_req_q  <= rst_req_d;
        end
    end

    assign OSD_EN_o     = osd_en_q;
    assign CURSOR_o     = cursor_q;
    assign BRIGHT_MAX_o = bright_q;
    assign REGION_o     = region_q;
    assign SCANLINE_o   = scanline_q;
    assign RST_REQ_o    = rst_req_q;

endmodule

// File: tb/tb_snes_osd_menu.sv
// Bench for snes_osd_menu: directed vector table, hand-written corner
// sequences and random pad words checked against a behavioural model.
module tb_snes_osd_menu;

    localparam int HF = 8;
    localparam int RD = 20;
    localparam int RR = 4;

    logic        clk, rst, pad_valid;
    logic [15:0] pad;
    logic        osd_en, rst_req, osd_en1, rst_req1;
    logic [1:0]  cursor, region, scanline, cursor1, region1, scanline1;
    logic [3:0]  bright, bright1;

    int checks;
    int errors;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [15:0] pad;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[$];

    // behavioural model
    int   m_osd, m_cur, m_bri, m_reg, m_scn, m_rst, m_hold, m_run;
    bit   m_wait_open, m_wait_close;
    logic [11:0] m_prev;

    snes_osd_menu #(.HOLD_FRAMES(HF), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_dut (
        .CLK_i(clk), .RST_i(rst), .PAD_i(pad), .PAD_VALID_i(pad_valid),
        .OSD_EN_o(osd_en), .CURSOR_o(cursor), .BRIGHT_MAX_o(bright),
        .REGION_o(region), .SCANLINE_o(scanline), .RST_REQ_o(rst_req)
    );

    snes_osd_menu #(.HOLD_FRAMES(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_dut_hf1 (
        .CLK_i(clk), .RST_i(rst), .PAD_i(pad), .PAD_VALID_i(pad_valid),
        .OSD_EN_o(osd_en1), .CURSOR_o(cursor1), .BRIGHT_MAX_o(bright1),
        .REGION_o(region1), .SCANLINE_o(scanline1), .RST_REQ_o(rst_req1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pk(input int osd, input int cur, input int bri,
                                       input int rg, input int sc, input int rs);
        return {1'(osd), 2'(cur), 4'(bri), 2'(rg), 2'(sc), 1'(rs)};
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [11:0] model_pack();
        return pk(m_osd, m_cur, m_bri, m_reg, m_scn, m_rst);
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_outputs(input string tag, input logic [11:0] e);
        check_val({tag, " osd_en"},   int'(osd_en),   int'(e[11]));
        check_val({tag, " cursor"},   int'(cursor),   int'(e[10:9]));
        check_val({tag, " bright"},   int'(bright),   int'(e[8:5]));
        check_val({tag, " region"},   int'(region),   int'(e[4:3]));
        check_val({tag, " scanline"}, int'(scanline), int'(e[2:1]));
        check_val({tag, " rst_req"},  int'(rst_req),  int'(e[0]));
    endtask

    task automatic model_reset();
        m_osd = 0; m_cur = 0; m_bri = 15; m_reg = 0; m_scn = 0; m_rst = 0;
        m_hold = 0; m_run = 0; m_wait_open = 0; m_wait_close = 0; m_prev = 12'h000;
    endtask

    task automatic model_word(input logic [15:0] w);
        logic [11:0] p, nw;
        logic in_menu, mv_up, mv_dn, hit, inc, dec;
        int row, d;
        p  = (w[15:12] == 4'hF) ? ~w[11:0] : 12'h000;
        nw = p & ~m_prev;
        m_prev = p;
        m_rst  = 0;
        in_menu = (m_osd == 1) && !m_wait_close;
        mv_up = in_menu && !nw[0] && nw[4] && !nw[5];
        mv_dn = in_menu && !nw[0] && nw[5] && !nw[4];
        hit = 1'b0;
`ifdef SNES_OSD_MENU_AUTOREPEAT_EN
        if (!(p[6] ^ p[7]) || nw[6] || nw[7] || mv_up || mv_dn) m_run = 0;
        else m_run++;
        hit = (m_run >= RD) && (((m_run - RD) % RR) == 0);
`endif
        if (m_wait_open) begin
            if (p == 12'h000) begin m_osd = 1; m_cur = 0; m_wait_open = 0; end
        end else if (m_wait_close) begin
            if (p == 12'h000) begin m_osd = 0; m_wait_close = 0; end
        end else if (m_osd == 1) begin
            if (nw[0]) m_wait_close = 1;
            else begin
                row = m_cur;
                if (mv_up) m_cur = (m_cur + 3) % 4;
                else if (mv_dn) m_cur = (m_cur + 1) % 4;
                inc = nw[7] || (hit && p[7]);
                dec = nw[6] || (hit && p[6]);
                d = (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
                if (row == 0) m_bri = clampi(m_bri + d, 0, 15);
                if (row == 1) m_reg = clampi(m_reg + d, 0, 2);
                if (row == 2) m_scn = clampi(m_scn + d, 0, 3);
                if (row == 3 && nw[8]) begin m_rst = 1; m_wait_close = 1; end
            end
        end else begin
            if (p[2] && p[3] && p[10] && p[11]) begin
                m_hold++;
                if (m_hold >= HF) begin m_wait_open = 1; m_hold = 0; end
            end else begin
                m_hold = 0;
            end
        end
    endtask

    // One accepted word, then one idle cycle in which nothing may change
    // except the reset request dropping.
    task automatic send(input logic [15:0] w, input logic [11:0] e);
        @(negedge clk);
        pad = w; pad_valid = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        pad_valid = 1'b0;
        cmp_outputs("word", exp_q.pop_front());
        @(negedge clk);
        cmp_outputs("idle", e & 12'hFFE);
    endtask

    task automatic model_send(input logic [15:0] w);
        model_word(w);
        send(w, model_pack());
    endtask

    task automatic open_menu();
        for (int i = 0; i < HF; i++) model_send(16'hF0F3);
        model_send(16'hFFFF);
    endtask

    task automatic add(input logic [15:0] w, input int osd, input int cur, input int bri,
                       input int rg, input int sc, input int rs);
        vec_t v;
        v.pad = w;
        v.exp = pk(osd, cur, bri, rg, sc, rs);
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] w;
        int exp_b, sel, n;
        int dirs[8];
        checks = 0; errors = 0;
        dirs = '{4, 5, 6, 7, 6, 7, 8, 0};

        // directed vectors, starting from reset
        for (int i = 0; i < 8; i++) add(16'hF0F3, 0, 0, 15, 0, 0, 0);
        add(16'hFFFF, 1, 0, 15, 0, 0, 0);
        add(16'hFFEF, 1, 3, 15, 0, 0, 0); add(16'hFFFF, 1, 3, 15, 0, 0, 0);
        add(16'hFFDF, 1, 0, 15, 0, 0, 0); add(16'hFFFF, 1, 0, 15, 0, 0, 0);
        add(16'hFFDF, 1, 1, 15, 0, 0, 0); add(16'hFFFF, 1, 1, 15, 0, 0, 0);
        add(16'hFFCF, 1, 1, 15, 0, 0, 0); add(16'hFFFF, 1, 1, 15, 0, 0, 0);
        add(16'hFFEF, 1, 0, 15, 0, 0, 0); add(16'hFFFF, 1, 0, 15, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            add(16'hFF7F, 1, 0, 15, 0, 0, 0); add(16'hFFFF, 1, 0, 15, 0, 0, 0);
        end
        for (int i = 1; i <= 16; i++) begin
            add(16'hFFBF, 1, 0, clampi(15 - i, 0, 15), 0, 0, 0);
            add(16'hFFFF, 1, 0, clampi(15 - i, 0, 15), 0, 0, 0);
        end
        add(16'hFFDF, 1, 1, 0, 0, 0, 0); add(16'hFFFF, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            add(16'hFF7F, 1, 1, 0, clampi(i, 0, 2), 0, 0);
            add(16'hFFFF, 1, 1, 0, clampi(i, 0, 2), 0, 0);
        end
        add(16'hFFDF, 1, 2, 0, 2, 0, 0); add(16'hFFFF, 1, 2, 0, 2, 0, 0);
        add(16'hFFDF, 1, 3, 0, 2, 0, 0); add(16'hFFFF, 1, 3, 0, 2, 0, 0);
        add(16'hFEFF, 1, 3, 0, 2, 0, 1); add(16'hFFFF, 0, 3, 0, 2, 0, 0);
        // broken holds do not accumulate
        for (int i = 0; i < 7; i++) add(16'hF0F3, 0, 3, 0, 2, 0, 0);
        add(16'hFFFF, 0, 3, 0, 2, 0, 0);
        for (int i = 0; i < 7; i++) add(16'hF0F3, 0, 3, 0, 2, 0, 0);
        add(16'hFFFF, 0, 3, 0, 2, 0, 0);
        for (int i = 0; i < 8; i++) add(16'hF0F3, 0, 3, 0, 2, 0, 0);
        add(16'hFFFF, 1, 0, 0, 2, 0, 0);
        // non-standard pad ID: nothing registers
        add(16'h0FEF, 1, 0, 0, 2, 0, 0); add(16'h0FFF, 1, 0, 0, 2, 0, 0);
        add(16'h0F7F, 1, 0, 0, 2, 0, 0); add(16'h0FFE, 1, 0, 0, 2, 0, 0);
        add(16'h00F3, 1, 0, 0, 2, 0, 0);
        add(16'hFFFE, 1, 0, 0, 2, 0, 0); add(16'hFFFF, 0, 0, 0, 2, 0, 0);
        // scanline row
        for (int i = 0; i < 8; i++) add(16'hF0F3, 0, 0, 0, 2, 0, 0);
        add(16'hFFFF, 1, 0, 0, 2, 0, 0);
        add(16'hFFDF, 1, 1, 0, 2, 0, 0); add(16'hFFFF, 1, 1, 0, 2, 0, 0);
        add(16'hFFDF, 1, 2, 0, 2, 0, 0); add(16'hFFFF, 1, 2, 0, 2, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            add(16'hFF7F, 1, 2, 0, 2, clampi(i, 0, 3), 0);
            add(16'hFFFF, 1, 2, 0, 2, clampi(i, 0, 3), 0);
        end
        add(16'hFFBF, 1, 2, 0, 2, 2, 0); add(16'hFFFF, 1, 2, 0, 2, 2, 0);
        add(16'hFFFE, 1, 2, 0, 2, 2, 0); add(16'hFFFF, 0, 2, 0, 2, 2, 0);

        // clock/reset
        rst = 1'b1; pad = 16'hFFFF; pad_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        cmp_outputs("reset", pk(0, 0, 15, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            model_word(tbl[i].pad);
            send(tbl[i].pad, tbl[i].exp);
        end

        // Right held on row 0 from brightness 0
        open_menu();
        for (int k = 1; k <= 25; k++) begin
`ifdef SNES_OSD_MENU_AUTOREPEAT_EN
            exp_b = 1 + ((k >= 21) ? 1 : 0) + ((k >= 25) ? 1 : 0);
`else
            exp_b = 1;
`endif
            model_word(16'hFF7F);
            send(16'hFF7F, pk(1, 0, exp_b, 2, 2, 0));
        end
        model_send(16'hFFFF);
        model_send(16'hFFFE);
        model_send(16'hFFFF);

        // reset while row 3 + A is being accepted: request is dropped
        open_menu();
        for (int i = 0; i < 3; i++) begin model_send(16'hFFDF); model_send(16'hFFFF); end
        @(negedge clk);
        pad = 16'hFEFF; pad_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        pad_valid = 1'b0; rst = 1'b0;
        model_reset();
        cmp_outputs("midrst", pk(0, 0, 15, 0, 0, 0));
        @(negedge clk);
        cmp_outputs("midrst_idle", pk(0, 0, 15, 0, 0, 0));

        // HOLD_FRAMES = 1 opens on the first combo word
        model_send(16'hF0F3);
        check_val("hf1 after combo osd_en", int'(osd_en1), 0);
        model_send(16'hFFFF);
        check_val("hf1 open osd_en", int'(osd_en1), 1);
        check_val("hf1 open cursor", int'(cursor1), 0);
        model_send(16'hFFFE);
        check_val("hf1 closing osd_en", int'(osd_en1), 1);
        model_send(16'hFFFF);
        check_val("hf1 closed osd_en", int'(osd_en1), 0);

        // random pad traffic against the model
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: open_menu();
                1: model_send(16'hF0F3);
                2, 3, 4, 5: begin
                    w = 16'hFFFF;
                    w[dirs[$urandom_range(0, 7)]] = 1'b0;
                    if ($urandom_range(0, 3) == 0) w[$urandom_range(4, 7)] = 1'b0;
                    n = $urandom_range(1, 30);
                    for (int j = 0; j < n; j++) model_send(w);
                end
                6, 7: model_send(16'hFFFF);
                8: model_send(16'($urandom));
                default: model_send({4'($urandom_range(0, 14)), 12'($urandom)});
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
